uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Serial UART transmitter: one clk per bit, start/data(LSB first)/optional parity/stop.
// Define UART_TX_PARITY_EN to build in the parity bit and PARITY state.
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int unsigned CntWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
`else
    // Parity controls are accepted but have no effect in this build.
    logic unused_par;
    assign unused_par = ^{PAR_EN, PAR_TYP};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            data_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
`endif
        end
    end

    // Next-state logic; the frame configuration is only sampled on acceptance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (Data_Valid) begin
                    state_d   = StStart;
                    data_d    = P_DATA;
`ifdef UART_TX_PARITY_EN
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
`endif
                end
            end
            StStart: begin
                state_d = StData;
                cnt_d   = '0;
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? StParity : StStop;
`else
                    state_d = StStop;
`endif
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: state_d = StStop;
`endif
            StStop: state_d = StIdle;
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != StIdle);
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = data_d[cnt_d];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = (^data_d) ^ par_typ_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of directed frames plus reset and held-request sequences.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int total;
    int bad;

    uart_tx #(
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic       exp_par;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, " tx"}, TX_OUT, 1'b1);
        check({name, " busy"}, Busy, 1'b0);
    endtask

    // Called at the negedge just before the accepting posedge, with Data_Valid already high.
    task automatic expect_frame(input string name, input logic [7:0] d, input logic pe,
                                input logic ep, input int glitch_at, input bit keep_dv);
        logic exp_bits[11];
        int   len;
        logic use_par;
`ifdef UART_TX_PARITY_EN
        use_par = pe;
`else
        use_par = 1'b0;
`endif
        exp_bits[0] = 1'b0;
        for (int b = 0; b < 8; b++) exp_bits[b + 1] = d[b];
        if (use_par) begin
            exp_bits[9]  = ep;
            exp_bits[10] = 1'b1;
            len = 11;
        end else begin
            exp_bits[9] = 1'b1;
            len = 10;
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0 && !keep_dv) Data_Valid = 1'b0;
            if (i == glitch_at) begin
                P_DATA     = 8'hFF;
                Data_Valid = 1'b1;
            end else if (i == glitch_at + 1) begin
                Data_Valid = 1'b0;
            end
            check($sformatf("%s bit%0d tx", name, i), TX_OUT, exp_bits[i]);
            check($sformatf("%s bit%0d busy", name, i), Busy, 1'b1);
        end
        @(negedge clk);
        check_idle({name, " gap"});
    endtask

    task automatic request(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{"a5_nopar",   8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"a5_even",    8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"a5_odd",     8'hA5, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{"ff_odd",     8'hFF, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{"80_even",    8'h80, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{"00_nopar",   8'h00, 1'b0, 1'b1, 1'b0};

        rst        = 1'b0;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("in_reset");
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", i));
        end

        for (int v = 0; v < 6; v++) begin
            request(vecs[v].data, vecs[v].par_en, vecs[v].par_typ);
            expect_frame(vecs[v].name, vecs[v].data, vecs[v].par_en, vecs[v].exp_par, -10, 1'b0);
        end

        // Mid-frame request with new data must be ignored.
        request(8'h01, 1'b1, 1'b0);
        expect_frame("glitch", 8'h01, 1'b1, 1'b1, 3, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check_idle("glitch_dropped");
        end

        // Data_Valid held high: two frames with exactly one idle cycle between.
        request(8'h3C, 1'b1, 1'b1);
        expect_frame("held1", 8'h3C, 1'b1, 1'b1, -10, 1'b1);
        P_DATA = 8'hC3;
        expect_frame("held2", 8'hC3, 1'b1, 1'b1, -10, 1'b0);
        @(negedge clk);
        check_idle("held_end");

        // Reset during data bit 4 of a 0x00 frame.
        request(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) Data_Valid = 1'b0;
            check($sformatf("rstframe bit%0d busy", i), Busy, 1'b1);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("abort%0d", i));
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("post_rst%0d", i));
        end
        request(8'hA5, 1'b0, 1'b0);
        expect_frame("after_rst", 8'hA5, 1'b0, 1'b0, -10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
